led_count_scheduler: RTL and testbench

Round-robin scheduler that shares one LED up-counter between `NUM_REQ` requesters. Each requester posts a go pulse and owns a terminal count. The block grants the counter to one requester at a time, runs it at a divided tick rate up to that requester's limit, and pulses that requester's `done`. It sits between the debounced, edge-detected button pulses and the board LEDs, replacing the single-owner counting FSM.

---
 rtl/led_sched_pkg.sv | 21 ++
 rtl/tick_gen.sv | 35 +++
 rtl/led_count_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_led_count_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types for the LED count scheduler: FSM state encoding and the
// reset position of the round-robin pointer.
package led_sched_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // The pointer resets to NUM_REQ - LAST_RST_BACKOFF, i.e. the highest index,
    // so the search that starts at last+1 lands on requester 0 first.
    localparam int LAST_RST_BACKOFF = 1;

    function automatic int last_reset_value(input int num_req);
        return num_req - LAST_RST_BACKOFF;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Divided tick source: counts 0..DIV-1 and flags the last count.
// clr restarts the count so a fresh run sees a full DIV-cycle first tick.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign tick = (cnt_reg == CNT_W'(DIV - 1));

    always_comb begin
        if (clr || tick) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/led_count_scheduler.sv
// Round-robin owner of one shared LED up-counter across NUM_REQ requesters.
// Define LED_SCHED_HOLD_EN to display the final count for HOLD_TICKS ticks.
module led_count_scheduler
    import led_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int LED_W      = 4,
    parameter  int CLK_HZ     = 12_000_000,
    parameter  int TICK_HZ    = 4,
    parameter  int HOLD_TICKS = 2,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_btn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     abort,
    input  logic [NUM_REQ*LED_W-1:0] limit,
    output logic [LED_W-1:0]         led,
    output logic                     busy,
    output logic [ID_W-1:0]          grant_id,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       pending
);

    localparam int              DIV      = CLK_HZ / TICK_HZ;
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(last_reset_value(NUM_REQ));

    if (DIV < 2 || NUM_REQ < 2 || NUM_REQ > 8 || HOLD_TICKS < 1) begin : g_param_check
        $error("led_count_scheduler: illegal parameter combination");
    end

    state_t             state_reg, state_next;
    logic [LED_W-1:0]   led_reg, led_next;
    logic [LED_W-1:0]   lim_reg, lim_next;
    logic               busy_reg, busy_next;
    logic [ID_W-1:0]    grant_reg, grant_next;
    logic [ID_W-1:0]    last_reg, last_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [NUM_REQ-1:0] pending_reg, pending_next;
    logic [NUM_REQ-1:0] grant_clear;
    logic               tick;
    logic               tick_clr;
    logic               at_limit;
    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    logic [LED_W-1:0]   lim_arr [NUM_REQ];

`ifdef LED_SCHED_HOLD_EN
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              hold_last;

    assign hold_last = (hold_reg == HOLD_W'(HOLD_TICKS - 1));
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_limit
        assign lim_arr[gi] = limit[gi*LED_W +: LED_W];
    end

    tick_gen #(
        .DIV     (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_btn (rst_btn),
        .clr     (tick_clr),
        .tick    (tick)
    );

    assign at_limit = (led_reg == lim_reg);

    // First pending bit at or after last+1, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_reg) + k) % NUM_REQ;
            if (!sel_found && pending_reg[ID_W'(idx)]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    // A new req always wins over the grant clearing the same bit.
    assign pending_next = (pending_reg & ~grant_clear) | req;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (sel_found) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (tick && at_limit) begin
`ifdef LED_SCHED_HOLD_EN
                    state_next = S_HOLD;
`else
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef LED_SCHED_HOLD_EN
            S_HOLD: begin
                if (abort || (tick && hold_last)) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        led_next    = led_reg;
        lim_next    = lim_reg;
        busy_next   = busy_reg;
        grant_next  = grant_reg;
        last_next   = last_reg;
        done_next   = '0;
        grant_clear = '0;
        tick_clr    = 1'b0;
`ifdef LED_SCHED_HOLD_EN
        hold_next   = hold_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (sel_found) begin
                    grant_next  = sel_id;
                    last_next   = sel_id;
                    lim_next    = lim_arr[sel_id];
                    grant_clear = NUM_REQ'(1) << sel_id;
                    led_next    = '0;
                    busy_next   = 1'b1;
                    tick_clr    = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    led_next  = '0;
                    busy_next = 1'b0;
                end else if (tick) begin
                    if (at_limit) begin
                        done_next = NUM_REQ'(1) << grant_reg;
`ifdef LED_SCHED_HOLD_EN
                        hold_next = '0;
`else
                        led_next  = '0;
                        busy_next = 1'b0;
`endif
                    end else begin
                        led_next = led_reg + 1'b1;
                    end
                end
            end
`ifdef LED_SCHED_HOLD_EN
            S_HOLD: begin
                if (abort || (tick && hold_last)) begin
                    led_next  = '0;
                    busy_next = 1'b0;
                end else if (tick) begin
                    hold_next = hold_reg + 1'b1;
                end
            end
`endif
            default: begin
                led_next  = '0;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            led_reg     <= '0;
            lim_reg     <= '0;
            busy_reg    <= 1'b0;
            grant_reg   <= '0;
            last_reg    <= LAST_RST;
            done_reg    <= '0;
            pending_reg <= '0;
`ifdef LED_SCHED_HOLD_EN
            hold_reg    <= '0;
`endif
        end else begin
            led_reg     <= led_next;
            lim_reg     <= lim_next;
            busy_reg    <= busy_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            done_reg    <= done_next;
            pending_reg <= pending_next;
`ifdef LED_SCHED_HOLD_EN
            hold_reg    <= hold_next;
`endif
        end
    end

    assign led      = led_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;
    assign done     = done_reg;
    assign pending  = pending_reg;

endmodule

// File: tb/tb_led_count_scheduler.sv
// Directed bench for led_count_scheduler at DIV=4, three requesters, 4-bit LEDs,
// default build (no hold phase).
module tb_led_count_scheduler;

    logic        clk = 1'b0;
    logic        rst_btn = 1'b0;
    logic [2:0]  req = '0;
    logic        abort = 1'b0;
    logic [11:0] limit = '0;
    logic [3:0]  led;
    logic        busy;
    logic [1:0]  grant_id;
    logic [2:0]  done;
    logic [2:0]  pending;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_count_scheduler #(
        .NUM_REQ    (3),
        .LED_W      (4),
        .CLK_HZ     (16),
        .TICK_HZ    (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk      (clk),
        .rst_btn  (rst_btn),
        .req      (req),
        .abort    (abort),
        .limit    (limit),
        .led      (led),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done),
        .pending  (pending)
    );

    typedef struct {
        logic [2:0]  req;
        logic [11:0] limit;
        logic [3:0]  led;
        logic        busy;
        logic [1:0]  gid;
        logic [2:0]  done;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] r, input logic [11:0] lim,
                                input logic [3:0] l, input logic b, input logic [1:0] g,
                                input logic [2:0] d, input logic [2:0] p);
        vec_t v;
        v.req = r; v.limit = lim; v.led = l; v.busy = b; v.gid = g; v.done = d; v.pend = p;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        req = r;
        step();
        req = '0;
    endtask

    task automatic wait_done(input int idx, input string name);
        int n = 0;
        while (done === 3'b000 && n < 200) begin
            step();
            n++;
        end
        check({name, " done"}, done, 32'd1 << idx);
        $display("%s: done=%b led=%0d busy=%b", name, done, led, busy);
    endtask

    task automatic wait_busy(input int exp_id, input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({name, " busy"}, busy, 1);
        check({name, " grant"}, grant_id, exp_id);
        $display("%s: grant_id=%0d pending=%b", name, grant_id, pending);
    endtask

    task automatic wait_led(input int val, input string name);
        int n = 0;
        while (led !== 4'(val) && n < 200) begin
            step();
            n++;
        end
        check({name, " led"}, led, val);
    endtask

    initial begin
        // Simultaneous requests, all limits 0: grants 0,1,2, done on the first tick.
        add(3'b111, 12'h000, 0, 0, 0, 3'b000, 3'b111);
        for (int i = 0; i < 4; i++) add(3'b000, 12'h000, 0, 1, 0, 3'b000, 3'b110);
        add(3'b000, 12'h000, 0, 0, 0, 3'b001, 3'b110);
        for (int i = 0; i < 4; i++) add(3'b000, 12'h000, 0, 1, 1, 3'b000, 3'b100);
        add(3'b000, 12'h000, 0, 0, 1, 3'b010, 3'b100);
        for (int i = 0; i < 4; i++) add(3'b000, 12'h000, 0, 1, 2, 3'b000, 3'b000);
        add(3'b000, 12'h000, 0, 0, 2, 3'b100, 3'b000);
        add(3'b000, 12'h000, 0, 0, 2, 3'b000, 3'b000);
        // Single request, limit0 = 3: led steps every 4 cycles, then done[0].
        add(3'b001, 12'h003, 0, 0, 2, 3'b000, 3'b001);
        for (int i = 0; i < 4; i++) add(3'b000, 12'h003, 0, 1, 0, 3'b000, 3'b000);
        for (int s = 1; s <= 3; s++)
            for (int i = 0; i < 4; i++) add(3'b000, 12'h003, 4'(s), 1, 0, 3'b000, 3'b000);
        add(3'b000, 12'h003, 0, 0, 0, 3'b001, 3'b000);
        add(3'b000, 12'h003, 0, 0, 0, 3'b000, 3'b000);

        rst_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset led", led, 0);
        check("reset busy", busy, 0);
        check("reset grant", grant_id, 0);
        check("reset done", done, 0);
        check("reset pending", pending, 0);
        rst_btn = 1'b1;

        foreach (vecs[i]) begin
            req   = vecs[i].req;
            limit = vecs[i].limit;
            step();
            req = '0;
            $display("vec %0d: req=%b led=%0d busy=%b gid=%0d done=%b pending=%b",
                     i, vecs[i].req, led, busy, grant_id, done, pending);
            check($sformatf("vec%0d led", i), led, vecs[i].led);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d grant", i), grant_id, vecs[i].gid);
            check($sformatf("vec%0d done", i), done, vecs[i].done);
            check($sformatf("vec%0d pending", i), pending, vecs[i].pend);
        end

        // Fairness: 0 re-requests during its own run while 2 waits; 2 goes first.
        limit = 12'h101;
        pulse_req(3'b001);
        pulse_req(3'b100);
        pulse_req(3'b001);
        check("rr pending", pending, 3'b101);
        check("rr grant0", grant_id, 0);
        wait_done(0, "rr run0");
        wait_busy(2, "rr second");
        check("rr pending after 2", pending, 3'b001);
        wait_done(2, "rr run2");
        wait_busy(0, "rr third");
        check("rr pending empty", pending, 3'b000);
        wait_done(0, "rr rerun0");

        // limit 15: counts up to 15 with no wrap before done.
        begin
            int prev, maxv, bad, n;
            limit = 12'h00F;
            pulse_req(3'b001);
            prev = int'(led); maxv = prev; bad = 0; n = 0;
            step();
            while (done === 3'b000 && n < 200) begin
                if (int'(led) != prev && int'(led) != prev + 1) bad++;
                prev = int'(led);
                if (prev > maxv) maxv = prev;
                step();
                n++;
            end
            $display("limit15: max led=%0d done=%b", maxv, done);
            check("lim15 max", maxv, 15);
            check("lim15 last", prev, 15);
            check("lim15 steps", bad, 0);
            check("lim15 done", done, 3'b001);
            check("lim15 led after", led, 0);
            check("lim15 busy after", busy, 0);
        end

        // Abort at led=2 with requester 1 pending.
        limit = 12'h005;
        pulse_req(3'b001);
        pulse_req(3'b010);
        wait_led(2, "abort");
        check("abort pending before", pending, 3'b010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        $display("abort: led=%0d busy=%b done=%b pending=%b", led, busy, done, pending);
        check("abort led", led, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort pending kept", pending, 3'b010);
        step();
        check("abort regrant busy", busy, 1);
        check("abort regrant id", grant_id, 1);
        check("abort regrant pending", pending, 3'b000);
        wait_done(1, "abort run1");

        // Asynchronous reset mid-run, then requester 0 wins a three-way tie.
        limit = 12'h050;
        pulse_req(3'b010);
        step();
        pulse_req(3'b100);
        wait_led(1, "rst");
        rst_btn = 1'b0;
        #1;
        $display("reset: led=%0d busy=%b gid=%0d done=%b pending=%b", led, busy, grant_id, done, pending);
        check("midrst led", led, 0);
        check("midrst busy", busy, 0);
        check("midrst grant", grant_id, 0);
        check("midrst done", done, 0);
        check("midrst pending", pending, 0);
        #2;
        rst_btn = 1'b1;
        step();
        pulse_req(3'b111);
        check("postrst pending", pending, 3'b111);
        check("postrst idle", busy, 0);
        step();
        $display("post reset: grant_id=%0d pending=%b", grant_id, pending);
        check("postrst grant", grant_id, 0);
        check("postrst busy", busy, 1);
        check("postrst pending left", pending, 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
